// File: rtl/cirno_pkg.sv
// rtl/cirno_pkg.sv - shared fetch-path types and constants
package cirno_pkg;

    localparam int XLEN = 32;

    // Polarity of the shared core reset
    localparam logic RST_ACTIVE = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/ib_fifo.sv
// rtl/ib_fifo.sv - in-order storage, pointers and occupancy for the instruction buffer
module ib_fifo
    import cirno_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 2 * XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);

    // Pointers are exactly log2(DEPTH) bits so wrap is natural overflow
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [W-1:0]  mem [DEPTH];

    assign rdata = mem[rp];

    // Entry storage is data-only and deliberately left unreset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush returns everything to the origin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ib.sv
// rtl/ib.sv - instruction buffer between fetch read stage and decode
module ib
    import cirno_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = cirno_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_val,
    input  logic [XLEN-1:0]          i_in,
    input  logic [XLEN-1:0]          i_pc,
    output logic                     o_rdy,
    input  logic                     i_flush,
    output logic                     o_val,
    output logic [XLEN-1:0]          o_in,
    output logic [XLEN-1:0]          o_pc,
    input  logic                     i_d_rdy,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    logic            infl;
    logic            push;
    logic            pop;
    logic [CW-1:0]   cnt;
    logic [CW:0]     occ;
    logic [2*XLEN-1:0] rdata;

    // Occupancy counts the owed arrival so the read stage can never overrun us
    assign occ   = {1'b0, cnt} + {{CW{1'b0}}, infl};
    assign o_rdy = (occ < DEPTH_V) & ~i_flush & (rst != RST_ACTIVE);

    assign o_val = (cnt != '0) & ~i_flush;
    assign push  = i_val & ~i_flush;
    assign pop   = o_val & i_d_rdy;
    assign o_cnt = cnt;
    assign {o_in, o_pc} = rdata;

    // A granted request this cycle means one instruction is owed next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            infl <= 1'b0;
        end else begin
            infl <= o_rdy;
        end
    end

    ib_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (i_flush),
        .wdata ({i_in, i_pc}),
        .rdata (rdata),
        .cnt   (cnt)
    );

endmodule

// File: tb/tb_ib.sv
// tb/tb_ib.sv - self-checking bench for the instruction buffer
module tb_ib;
    import cirno_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_val = 1'b0;
    logic [XLEN-1:0] i_in = '0;
    logic [XLEN-1:0] i_pc = '0;
    logic            o_rdy;
    logic            i_flush = 1'b0;
    logic            o_val;
    logic [XLEN-1:0] o_in;
    logic [XLEN-1:0] o_pc;
    logic            i_d_rdy = 1'b0;
    logic [$clog2(DEPTH):0] o_cnt;

    int checks = 0;
    int failures = 0;

    fetch_pkt_t      q[$];
    logic [XLEN-1:0] out_pcs[$];
    logic            owed = 1'b0;
    logic [XLEN-1:0] next_pc = '0;
    int              pushes = 0;
    int              pops = 0;
    logic            s_val;
    logic            s_rdy;
    int              s_cnt;

    ib #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_val   (i_val),
        .i_in    (i_in),
        .i_pc    (i_pc),
        .o_rdy   (o_rdy),
        .i_flush (i_flush),
        .o_val   (o_val),
        .o_in    (o_in),
        .o_pc    (o_pc),
        .i_d_rdy (i_d_rdy),
        .o_cnt   (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the queue model, advance the model
    task automatic cyc(input logic fl, input logic dr, input logic rs);
        fetch_pkt_t pkt;
        logic       ev;
        logic       er;
        int         ec;
        @(posedge clk);
        #1;
        rst     = rs;
        i_flush = fl;
        i_d_rdy = dr;
        if (rs) begin
            q.delete();
            owed = 1'b0;
        end
        i_val     = owed;
        pkt.instr = $urandom;
        pkt.pc    = next_pc;
        i_in      = pkt.instr;
        i_pc      = pkt.pc;
        #1;
        ev = (q.size() != 0) && !fl && !rs;
        er = ((q.size() + int'(owed)) < DEPTH) && !fl && !rs;
        ec = q.size();
        s_val = o_val;
        s_rdy = o_rdy;
        s_cnt = int'(o_cnt);
        check("o_val", 64'(o_val), 64'(ev));
        check("o_rdy", 64'(o_rdy), 64'(er));
        check("o_cnt", 64'(o_cnt), 64'(ec));
        if (ev) begin
            check("o_in", 64'(o_in), 64'(q[0].instr));
            check("o_pc", 64'(o_pc), 64'(q[0].pc));
        end
        if (!rs) begin
            if (fl) begin
                q.delete();
            end else begin
                if (ev && dr) begin
                    out_pcs.push_back(q[0].pc);
                    void'(q.pop_front());
                    pops++;
                end
                if (owed) begin
                    checks++;
                    assert (q.size() < DEPTH) else begin
                        failures++;
                        $error("FAIL overflow observed=%0d expected<%0d", q.size(), DEPTH);
                    end
                    q.push_back(pkt);
                    pushes++;
                    next_pc = next_pc + 32'd4;
                end
            end
        end
        owed = er;
    endtask

    initial begin
        int n;
        // Reset state
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_val", 64'(s_val), 64'd0);
        check("rst_cnt", 64'(s_cnt), 64'd0);

        // Streaming with decode always ready
        next_pc = '0;
        pops = 0;
        out_pcs.delete();
        cyc(1'b0, 1'b1, 1'b0);
        check("first_rdy", 64'(s_rdy), 64'd1);
        n = 0;
        while (pops < 16 && n < 100) begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
            check("stream_rdy", 64'(s_rdy), 64'd1);
            check("stream_cnt_le1", 64'(s_cnt <= 1), 64'd1);
        end
        check("stream_count", 64'(pops), 64'd16);
        for (int i = 0; i < 16 && i < out_pcs.size(); i++) begin
            check("stream_order", 64'(out_pcs[i]), 64'(i * 4));
        end

        // Fill under stall, then drain
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0);
        check("fill_cnt", 64'(s_cnt), 64'd4);
        check("fill_rdy", 64'(s_rdy), 64'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);

        // Random decode backpressure across many pointer wraps
        n = 0;
        pushes = 0;
        while (pushes < 200 && n < 2000) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        check("wrap_pushes", 64'(pushes >= 200), 64'd1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);

        // Flush with two held entries and one arrival in flight
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("flush_cnt_before", 64'(s_cnt), 64'd2);
        check("flush_val", 64'(s_val), 64'd0);
        check("flush_rdy", 64'(s_rdy), 64'd0);
        next_pc = 32'h100;
        out_pcs.delete();
        cyc(1'b0, 1'b1, 1'b0);
        check("post_flush_cnt", 64'(s_cnt), 64'd0);
        check("post_flush_rdy", 64'(s_rdy), 64'd1);
        n = 0;
        while (out_pcs.size() == 0 && n < 20) begin
            cyc(1'b0, 1'b1, 1'b0);
            n++;
        end
        check("post_flush_first", 64'(out_pcs.size() > 0 ? out_pcs[0] : 32'hdead), 64'h100);

        // Reset mid-stream with three entries held
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
        check("pre_rst_cnt", 64'(s_cnt), 64'd3);
        cyc(1'b0, 1'b0, 1'b1);
        check("mid_rst_val", 64'(s_val), 64'd0);
        check("mid_rst_cnt", 64'(s_cnt), 64'd0);
        check("mid_rst_rdy", 64'(s_rdy), 64'd0);
        cyc(1'b0, 1'b1, 1'b0);
        check("rst_release_rdy", 64'(s_rdy), 64'd1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
